store_byte_serializer: RTL and testbench
========================================

Name: store_byte_serializer

Overview:
- Write-side counterpart of the CPU's immediate/load sign extension: narrows a 32-bit register value to byte, half or word per the store funct3.
- Serializes the result as little-endian byte writes onto the 8-bit data-memory/peripheral bus, using a valid/ack handshake.
- Sits between the single-cycle core's execute stage and the byte-wide data bus. The core stalls on BUSY.

Parameters:
- ADDR_W, 32, width of the byte address bus.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle store request; sampled only in IDLE.
- FUNCT3  input  3  store type: 000 SB, 001 SH, 010 SW; all other codes are illegal.
- ADDR  input  ADDR_W  byte address of the store.
- WDATA  input  32  register data (rs2).
- BUSY  output  1  transfer in progress.
- DONE  output  1  one-cycle pulse when all bytes have been acknowledged.
- ERR  output  1  one-cycle pulse when a request is rejected.
- MEM_ADDR  output  ADDR_W  byte address of the current beat.
- MEM_WDATA  output  8  byte data of the current beat.
- MEM_WE  output  1  write valid.
- MEM_ACK  input  1  memory accepts the current beat when MEM_ACK=1 and MEM_WE=1.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; BUSY, DONE, ERR and MEM_WE = 0; MEM_ADDR and MEM_WDATA = 0; internal data, address and counter registers = 0.
- An in-flight transfer aborted by RST is lost. No DONE is generated for it.
- States: IDLE, SEND, FINISH, FAIL.
- IDLE:
  - START=0: stay in IDLE.
  - START=1 with a legal, aligned request: latch ADDR, WDATA, and beat count N (SB=1, SH=2, SW=4); clear the beat index k to 0; go to SEND.
  - START=1 with an illegal FUNCT3, or a misaligned request (SH with ADDR[0]=1, SW with ADDR[1:0]!=00): go to FAIL. No MEM_WE is ever asserted for it.
- SEND:
  - Outputs: MEM_WE=1, BUSY=1, MEM_ADDR = latched ADDR + k (modulo 2^ADDR_W), MEM_WDATA = latched WDATA[8k+7:8k].
  - MEM_ACK=0: hold all outputs stable. No timeout.
  - MEM_ACK=1 with k<N-1: k increments and the next beat is presented in the following cycle.
  - MEM_ACK=1 with k=N-1: go to FINISH.
- FINISH: DONE=1, BUSY=0, MEM_WE=0 for exactly one cycle, then IDLE.
- FAIL: ERR=1, BUSY=0 for exactly one cycle, then IDLE.
- START in any state other than IDLE is ignored; inputs are not re-latched.
- START in the FINISH or FAIL cycle is also ignored. The core must re-issue it.
- Latency: request accepted at edge T. First beat is valid in cycle T+1. With MEM_ACK tied high, DONE appears N cycles after the first beat (SW: beats at T+1..T+4, DONE at T+5).
- Address wrap: ADDR=FFFF_FFFF with SB writes that address only. A legal aligned SW never wraps.
- All outputs are registered (Moore). MEM_ADDR and MEM_WDATA retain their last beat values outside SEND.
- Only bits WDATA[8N-1:0] are ever driven onto the bus. Upper bits are discarded (truncation, the inverse of sign extension).

Test Plan:
- Reset then idle: RST=1 mid-SEND of an SW after 2 acks -> MEM_WE=0, BUSY=0 immediately. No further beats and no DONE after RST releases.
- SW, ADDR=0000_0100, WDATA=DEADBEEF, MEM_ACK=1 -> beats (100,EF), (101,BE), (102,AD), (103,DE) on consecutive cycles; DONE one cycle after the last beat; BUSY low with DONE.
- SH, ADDR=0000_0202, WDATA=1234_8001, MEM_ACK low for 3 cycles on beat 0 -> (202,01) held 4 cycles; then (203,80); then DONE. 0x12 and 0x34 never appear on the bus.
- SB, ADDR=FFFF_FFFF, WDATA=0000_00A5 -> single beat (FFFF_FFFF,A5), then DONE.
- Rejections: SH at ADDR=...001, SW at ADDR=...002, FUNCT3=011 -> ERR pulses one cycle each, MEM_WE stays 0, no DONE.
- START asserted every cycle during an SW transfer and in its FINISH cycle -> only one transfer runs; inputs are not re-latched; a START in the cycle after FINISH starts a new transfer.

Source files
------------

// File: rtl/store_byte_serializer_if.sv
// Handshake bundle between the core-side store request, the serializer and
// the byte-wide data-memory/peripheral bus.
//   start/funct3/addr/wdata : store request from the execute stage
//   busy/done/err           : status back to the core
//   mem_addr/mem_wdata/mem_we/mem_ack : byte-wide write bus
// modport master : the core plus the memory (request and ack side)
// modport slave  : the serializer
interface store_byte_serializer_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_ack;

  modport master (
    output start, funct3, addr, wdata, mem_ack,
    input  busy, done, err, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  start, funct3, addr, wdata, mem_ack,
    output busy, done, err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/store_byte_serializer.sv
// Store byte serializer: narrows a 32-bit register value to byte, half or
// word according to the store funct3 (000 SB, 001 SH, 010 SW) and emits it
// as little-endian byte writes with a valid/ack handshake.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : store_byte_serializer_if.slave (request, status and byte bus)
// Every output is a register, so the bus sees clean Moore outputs; address
// and data hold their last beat values outside SEND.
module store_byte_serializer #(
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  store_byte_serializer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, FINISH, FAIL} state_t;

  state_t            state, state_n;

  logic [ADDR_W-1:0] addr_p0, addr_n;
  logic [31:0]       data_p0, data_n;
  logic [1:0]        last_p0, last_n;
  logic [1:0]        k_p0, k_n;

  logic              busy_p1, busy_n;
  logic              done_p1, done_n;
  logic              err_p1, err_n;
  logic              we_p1, we_n;
  logic [ADDR_W-1:0] maddr_p1, maddr_n;
  logic [7:0]        mdata_p1, mdata_n;

  logic              legal;
  logic [1:0]        last_req;
  logic [1:0]        k_inc;

  // Request decode: legal store type and natural alignment; last_req is N-1.
  always_comb begin
    legal    = 1'b0;
    last_req = 2'd0;
    case (bus.funct3)
      3'b000: begin legal = 1'b1;                      last_req = 2'd0; end
      3'b001: begin legal = ~bus.addr[0];              last_req = 2'd1; end
      3'b010: begin legal = (bus.addr[1:0] == 2'b00);  last_req = 2'd3; end
      default: begin legal = 1'b0;                     last_req = 2'd0; end
    endcase
  end

  assign k_inc = k_p0 + 2'd1;

  always_comb begin
    state_n = state;
    addr_n  = addr_p0;
    data_n  = data_p0;
    last_n  = last_p0;
    k_n     = k_p0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    we_n    = 1'b0;
    maddr_n = maddr_p1;
    mdata_n = mdata_p1;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (legal) begin
            state_n = SEND;
            addr_n  = bus.addr;
            data_n  = bus.wdata;
            last_n  = last_req;
            k_n     = 2'd0;
            busy_n  = 1'b1;
            we_n    = 1'b1;
            maddr_n = bus.addr;
            mdata_n = bus.wdata[7:0];
          end else begin
            state_n = FAIL;
            err_n   = 1'b1;
          end
        end
      end
      SEND: begin
        busy_n = 1'b1;
        we_n   = 1'b1;
        if (bus.mem_ack) begin
          if (k_p0 == last_p0) begin
            state_n = FINISH;
            busy_n  = 1'b0;
            we_n    = 1'b0;
            done_n  = 1'b1;
          end else begin
            // Next beat: address wraps naturally modulo 2^ADDR_W.
            k_n     = k_inc;
            maddr_n = addr_p0 + ADDR_W'(k_inc);
            mdata_n = data_p0[{k_inc, 3'b000} +: 8];
          end
        end
      end
      FINISH:  state_n = IDLE;
      FAIL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: latched request and beat index; stage p1: registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_p0  <= '0;
      data_p0  <= '0;
      last_p0  <= '0;
      k_p0     <= '0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      err_p1   <= 1'b0;
      we_p1    <= 1'b0;
      maddr_p1 <= '0;
      mdata_p1 <= '0;
    end else begin
      state    <= state_n;
      addr_p0  <= addr_n;
      data_p0  <= data_n;
      last_p0  <= last_n;
      k_p0     <= k_n;
      busy_p1  <= busy_n;
      done_p1  <= done_n;
      err_p1   <= err_n;
      we_p1    <= we_n;
      maddr_p1 <= maddr_n;
      mdata_p1 <= mdata_n;
    end
  end

  assign bus.busy      = busy_p1;
  assign bus.done      = done_p1;
  assign bus.err       = err_p1;
  assign bus.mem_we    = we_p1;
  assign bus.mem_addr  = maddr_p1;
  assign bus.mem_wdata = mdata_p1;

endmodule

// File: tb/tb_store_byte_serializer.sv
// Directed bench for store_byte_serializer: stimulus is driven and outputs
// are checked on the falling clock edge.
module tb_store_byte_serializer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic watch;
  logic seen_hi;
  int   we_cnt;
  int   done_cnt;

  store_byte_serializer_if #(.ADDR_W(32)) bus ();

  store_byte_serializer #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags any upper SH byte that leaks onto the bus.
  always @(negedge clk) begin
    if (watch && bus.mem_we && (bus.mem_wdata == 8'h12 || bus.mem_wdata == 8'h34))
      seen_hi = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [7:0] d);
    chk({tag, " we"},   64'(bus.mem_we), 64'd1);
    chk({tag, " busy"}, 64'(bus.busy), 64'd1);
    chk({tag, " done"}, 64'(bus.done), 64'd0);
    chk({tag, " addr"}, 64'(bus.mem_addr), 64'(a));
    chk({tag, " data"}, 64'(bus.mem_wdata), 64'(d));
  endtask

  task automatic fin(input string tag);
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " we"},   64'(bus.mem_we), 64'd0);
  endtask

  task automatic req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.addr   = a;
    bus.wdata  = d;
  endtask

  logic [2:0]  rej_f [3];
  logic [31:0] rej_a [3];

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    watch      = 1'b0;
    seen_hi    = 1'b0;
    we_cnt     = 0;
    done_cnt   = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.addr   = '0;
    bus.wdata  = '0;
    bus.mem_ack = 1'b0;
    rej_f[0] = 3'b001; rej_a[0] = 32'h0000_0001;
    rej_f[1] = 3'b010; rej_a[1] = 32'h0000_0002;
    rej_f[2] = 3'b011; rej_a[2] = 32'h0000_0000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst err",  64'(bus.err), 64'd0);
    chk("rst we",   64'(bus.mem_we), 64'd0);
    chk("rst addr", 64'(bus.mem_addr), 64'd0);
    chk("rst data", 64'(bus.mem_wdata), 64'd0);
    rst = 1'b0;

    // SW DEADBEEF at 0x100, ack tied high
    @(negedge clk);
    bus.mem_ack = 1'b1;
    req(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    @(negedge clk); bus.start = 1'b0; beat("sw b0", 32'h100, 8'hEF);
    @(negedge clk); beat("sw b1", 32'h101, 8'hBE);
    @(negedge clk); beat("sw b2", 32'h102, 8'hAD);
    @(negedge clk); beat("sw b3", 32'h103, 8'hDE);
    @(negedge clk); fin("sw fin");
    chk("sw hold addr", 64'(bus.mem_addr), 64'h103);
    chk("sw hold data", 64'(bus.mem_wdata), 64'hDE);
    @(negedge clk);
    chk("sw done pulse", 64'(bus.done), 64'd0);

    // SH 12348001 at 0x202, ack held low for three cycles on beat 0
    bus.mem_ack = 1'b0;
    watch = 1'b1;
    req(3'b001, 32'h0000_0202, 32'h1234_8001);
    @(negedge clk); bus.start = 1'b0; beat("sh b0 w1", 32'h202, 8'h01);
    @(negedge clk); beat("sh b0 w2", 32'h202, 8'h01);
    @(negedge clk); beat("sh b0 w3", 32'h202, 8'h01);
    @(negedge clk); beat("sh b0 ack", 32'h202, 8'h01);
    bus.mem_ack = 1'b1;
    @(negedge clk); beat("sh b1", 32'h203, 8'h80);
    @(negedge clk); fin("sh fin");
    watch = 1'b0;
    chk("sh upper bytes", 64'(seen_hi), 64'd0);

    // SB at the top of the address space
    @(negedge clk);
    req(3'b000, 32'hFFFF_FFFF, 32'h0000_00A5);
    @(negedge clk); bus.start = 1'b0; beat("sb b0", 32'hFFFF_FFFF, 8'hA5);
    @(negedge clk); fin("sb fin");

    // Rejections: misaligned SH, misaligned SW, illegal funct3
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req(rej_f[i], rej_a[i], 32'h5555_AAAA);
      @(negedge clk); bus.start = 1'b0;
      chk($sformatf("rej%0d err", i),  64'(bus.err), 64'd1);
      chk($sformatf("rej%0d we", i),   64'(bus.mem_we), 64'd0);
      chk($sformatf("rej%0d busy", i), 64'(bus.busy), 64'd0);
      chk($sformatf("rej%0d done", i), 64'(bus.done), 64'd0);
      @(negedge clk);
      chk($sformatf("rej%0d err pulse", i), 64'(bus.err), 64'd0);
      chk($sformatf("rej%0d we after", i),  64'(bus.mem_we), 64'd0);
    end

    // START held high through an SW and its FINISH cycle
    @(negedge clk);
    req(3'b010, 32'h0000_0010, 32'h1122_3344);
    @(negedge clk);
    req(3'b000, 32'h0000_0080, 32'hAABB_CCDD);
    beat("st b0", 32'h10, 8'h44);
    @(negedge clk); beat("st b1", 32'h11, 8'h33);
    @(negedge clk); beat("st b2", 32'h12, 8'h22);
    @(negedge clk); beat("st b3", 32'h13, 8'h11);
    @(negedge clk); fin("st fin");
    @(negedge clk);
    chk("st idle we",   64'(bus.mem_we), 64'd0);
    chk("st idle busy", 64'(bus.busy), 64'd0);
    chk("st idle done", 64'(bus.done), 64'd0);
    @(negedge clk); bus.start = 1'b0; beat("st new b0", 32'h80, 8'hDD);
    @(negedge clk); fin("st new fin");

    // Reset in the middle of an SW after two acks
    @(negedge clk);
    req(3'b010, 32'h0000_0200, 32'h0102_0304);
    @(negedge clk); bus.start = 1'b0; beat("ab b0", 32'h200, 8'h04);
    @(negedge clk); beat("ab b1", 32'h201, 8'h03);
    @(negedge clk); beat("ab b2", 32'h202, 8'h02);
    rst = 1'b1;
    #1;
    chk("ab rst we",   64'(bus.mem_we), 64'd0);
    chk("ab rst busy", 64'(bus.busy), 64'd0);
    chk("ab rst addr", 64'(bus.mem_addr), 64'd0);
    chk("ab rst data", 64'(bus.mem_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_we) we_cnt++;
      if (bus.done)   done_cnt++;
    end
    chk("ab no beats", 64'(we_cnt), 64'd0);
    chk("ab no done",  64'(done_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
